char_gen_param: RTL and testbench

- Parametrised text-mode character generator for the VGA pipeline; successor to the fixed 80x30, 8x16 character generator.
- Holds an internal character/colour RAM with a data-side read/write port.
- Renders one pixel per cycle through a fixed 3-stage pipeline, with a valid qualifier.
- Adds per-character blink, a hardware cursor and out-of-area blanking.
- Sits between the VGA timing generator and the colour output register; the data port connects to the I/O system bus.

---
 rtl/char_gen_pkg.sv | 21 ++
 rtl/char_font_rom.sv | 25 ++
 rtl/char_gen_param.sv | 141 ++++++++++++++
 tb/tb_char_gen_param.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/char_gen_pkg.sv
// Cell-word layout and shared constants for the parametrised text-mode character generator.
package char_gen_pkg;

   localparam int BG_HI     = 31;
   localparam int BG_LO     = 20;
   localparam int FG_HI     = 19;
   localparam int FG_LO     = 8;
   localparam int BLINK_BIT = 7;
   localparam int CHAR_HI   = 6;
   localparam int CHAR_LO   = 0;

   localparam int CURSOR_LINES = 2;

   typedef struct packed {
      logic [11:0] bg;
      logic [11:0] fg;
      logic        blink;
      logic [6:0]  code;
   } cell_t;

endpackage

// File: rtl/char_font_rom.sv
// Glyph ROM: one FONT_W-bit row per {code, line}, registered synchronous read.
module char_font_rom #(
   parameter int  FONT_W    = 8,
   parameter int  FONT_H    = 16,
   parameter      FONT_FILE = "font.mem",
   localparam int YW        = $clog2(FONT_H),
   localparam int AW        = 7 + YW
) (
   input  logic              clk_i,
   input  logic [AW-1:0]     addr_i,
   output logic [FONT_W-1:0] data_o
);

   // Built-in glyph pattern; an empty font name yields a blank font.
   localparam bit HAS_FONT = |FONT_FILE;

   function automatic logic [FONT_W-1:0] glyph_row(input logic [6:0] code,
                                                   input logic [YW-1:0] line);
      return FONT_W'((32'(code) * 32'd3) ^ (32'(line) * 32'd37));
   endfunction

   always_ff @(posedge clk_i)
      data_o <= HAS_FONT ? glyph_row(addr_i[AW-1:YW], addr_i[YW-1:0]) : '0;

endmodule

// File: rtl/char_gen_param.sv
// Text-mode character generator: cell RAM with data port, 3-stage pixel pipeline, blink and cursor.
module char_gen_param
   import char_gen_pkg::*;
#(
   parameter int  FONT_W       = 8,
   parameter int  FONT_H       = 16,
   parameter int  COLS         = 80,
   parameter int  ROWS         = 30,
   parameter int  COLOR_W      = 12,
   parameter int  BLINK_FRAMES = 30,
   parameter      FONT_FILE    = "font.mem",
   localparam int AW           = $clog2(COLS * ROWS),
   localparam int CCW          = (COLS > 1) ? $clog2(COLS) : 1,
   localparam int RCW          = (ROWS > 1) ? $clog2(ROWS) : 1
) (
   input  logic               clk_vga,
   input  logic               rst,
   input  logic               data_we,
   input  logic [AW-1:0]      data_addr,
   input  logic [31:0]        data_write_value,
   output logic [31:0]        data_read_value,
   input  logic               frame_start,
   input  logic               cursor_en,
   input  logic [CCW-1:0]     cursor_col,
   input  logic [RCW-1:0]     cursor_row,
   input  logic               pixel_valid_in,
   input  logic [9:0]         pixel_x,
   input  logic [9:0]         pixel_y,
   output logic               pixel_valid_out,
   output logic [COLOR_W-1:0] pixel_out
);

   localparam int CELLS = COLS * ROWS;
   localparam int XW    = $clog2(FONT_W);
   localparam int YW    = $clog2(FONT_H);
   localparam int BW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [31:0] ram [CELLS];

   logic [9-XW:0]  col;
   logic [9-YW:0]  row;
   logic [XW-1:0]  xo;
   logic [YW-1:0]  yo;
   logic           in_area, hit, addr_ok;
   logic [AW-1:0]  vga_addr;

   cell_t          cell_q;
   logic [XW-1:0]  s1_xo_q, s2_xo_q;
   logic [YW-1:0]  s1_yo_q;
   logic           s1_area_q, s1_hit_q, s1_vld_q;
   logic [COLOR_W-1:0] s2_fg_q, s2_bg_q;
   logic           s2_blink_q, s2_area_q, s2_hit_q, s2_vld_q;
   logic [FONT_W-1:0] glyph;

   logic [BW-1:0]  blink_cnt_q, blink_cnt_d;
   logic           blink_phase_q, blink_phase_d;
   logic           fg_bit, sel_fg;
   logic [COLOR_W-1:0] pixel_d;

   always_comb begin
      col      = pixel_x[9:XW];
      row      = pixel_y[9:YW];
      xo       = pixel_x[XW-1:0];
      yo       = pixel_y[YW-1:0];
      in_area  = (10'(col) < 10'(COLS)) && (10'(row) < 10'(ROWS));
      vga_addr = in_area ? (AW'(row) * AW'(COLS) + AW'(col)) : '0;
      // Cursor requires a real cell, so out-of-grid cursor positions never match.
      hit      = cursor_en && in_area
                 && (10'(col) == 10'(cursor_col)) && (10'(row) == 10'(cursor_row))
                 && (int'(yo) >= FONT_H - CURSOR_LINES);
      addr_ok  = int'(data_addr) < CELLS;
   end

   always_ff @(posedge clk_vga) begin
      if (data_we && addr_ok)
         ram[data_addr] <= data_write_value;
      cell_q     <= cell_t'(ram[vga_addr]);
      s1_xo_q    <= xo;
      s1_yo_q    <= yo;
      s1_area_q  <= in_area;
      s1_hit_q   <= hit;
      s2_fg_q    <= COLOR_W'(cell_q[FG_HI:FG_LO]);
      s2_bg_q    <= COLOR_W'(cell_q[BG_HI:BG_LO]);
      s2_blink_q <= cell_q[BLINK_BIT];
      s2_xo_q    <= s1_xo_q;
      s2_area_q  <= s1_area_q;
      s2_hit_q   <= s1_hit_q;
   end

   char_font_rom #(
      .FONT_W    (FONT_W),
      .FONT_H    (FONT_H),
      .FONT_FILE (FONT_FILE)
   ) u_font (
      .clk_i  (clk_vga),
      .addr_i ({cell_q[CHAR_HI:CHAR_LO], s1_yo_q}),
      .data_o (glyph)
   );

   always_comb begin
      fg_bit = glyph[XW'(FONT_W - 1) - s2_xo_q];
      sel_fg = fg_bit && !(s2_blink_q && blink_phase_q);
      if (s2_hit_q && !blink_phase_q)
         sel_fg = !sel_fg;
      pixel_d = !s2_area_q ? '0 : (sel_fg ? s2_fg_q : s2_bg_q);
   end

   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_start) begin
         if (int'(blink_cnt_q) == BLINK_FRAMES - 1) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_vga or posedge rst) begin
      if (rst) begin
         data_read_value <= '0;
         s1_vld_q        <= 1'b0;
         s2_vld_q        <= 1'b0;
         pixel_valid_out <= 1'b0;
         pixel_out       <= '0;
         blink_cnt_q     <= '0;
         blink_phase_q   <= 1'b0;
      end else begin
         data_read_value <= addr_ok ? ram[data_addr] : '0;
         s1_vld_q        <= pixel_valid_in;
         s2_vld_q        <= s1_vld_q;
         pixel_valid_out <= s2_vld_q;
         pixel_out       <= pixel_d;
         blink_cnt_q     <= blink_cnt_d;
         blink_phase_q   <= blink_phase_d;
      end
   end

endmodule

// File: tb/tb_char_gen_param.sv
// Self-checking bench for char_gen_param: data-port table, directed pixel sequences, randomized scan.
module tb_char_gen_param;

   localparam int COLS = 80, ROWS = 30, FW = 8, FH = 16, BF = 30, N = COLS * ROWS;

   logic        clk = 1'b0, rst = 1'b1;
   logic        data_we = 1'b0;
   logic [11:0] data_addr = '0;
   logic [31:0] data_write_value = '0, data_read_value;
   logic        frame_start = 1'b0, cursor_en = 1'b0;
   logic [6:0]  cursor_col = '0;
   logic [4:0]  cursor_row = '0;
   logic        pixel_valid_in = 1'b0, pixel_valid_out;
   logic [9:0]  pixel_x = '0, pixel_y = '0;
   logic [11:0] pixel_out;

   always #5 clk = ~clk;

   char_gen_param #(
      .FONT_W(FW), .FONT_H(FH), .COLS(COLS), .ROWS(ROWS), .COLOR_W(12), .BLINK_FRAMES(BF)
   ) dut (
      .clk_vga(clk), .rst(rst), .data_we(data_we), .data_addr(data_addr),
      .data_write_value(data_write_value), .data_read_value(data_read_value),
      .frame_start(frame_start), .cursor_en(cursor_en), .cursor_col(cursor_col),
      .cursor_row(cursor_row), .pixel_valid_in(pixel_valid_in), .pixel_x(pixel_x),
      .pixel_y(pixel_y), .pixel_valid_out(pixel_valid_out), .pixel_out(pixel_out)
   );

   int n_vec = 0, n_bad = 0;
   logic [31:0] mem [N];
   int frames = 0;

   typedef struct { bit v; logic [11:0] pix; } exp_t;
   exp_t q[$];

   typedef struct {
      bit          we;
      logic [11:0] addr;
      logic [31:0] wdata;
      bit          chk;
      logic [31:0] exp_rd;
   } dvec_t;

   // Reference font: row bits of glyph 'code' on line 'line'.
   function automatic logic [7:0] font_row(int code, int line);
      return 8'(((code * 3) ^ (line * 37)) & 255);
   endfunction

   function automatic bit phase();
      return ((frames / BF) % 2) == 1;
   endfunction

   function automatic logic [11:0] model_pix(int x, int y);
      int col, row, xo, yo;
      logic [31:0] w;
      logic [7:0]  g;
      bit          sel;
      col = x / FW; row = y / FH; xo = x % FW; yo = y % FH;
      if (col >= COLS || row >= ROWS) return 12'h000;
      w   = mem[row * COLS + col];
      g   = font_row(int'(w[6:0]), yo);
      sel = g[7 - xo];
      if (w[7] && phase()) sel = 1'b0;
      if (cursor_en && col == int'(cursor_col) && row == int'(cursor_row)
          && yo >= FH - 2 && !phase())
         sel = !sel;
      return sel ? w[19:8] : w[31:20];
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock of stimulus; outputs are compared against the entry pushed three cycles earlier.
   task automatic pix(bit v, int x, int y);
      exp_t e;
      if (q.size() == 3) begin
         e = q.pop_front();
         check("valid_out", 32'(pixel_valid_out), 32'(e.v));
         if (e.v) check("pixel_out", 32'(pixel_out), 32'(e.pix));
      end
      pixel_valid_in = v; pixel_x = 10'(x); pixel_y = 10'(y);
      e.v = v; e.pix = model_pix(x, y);
      q.push_back(e);
      if (data_we && data_addr < N) mem[data_addr] = data_write_value;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic flush();
      repeat (3) pix(0, 0, 0);
   endtask

   task automatic wr(int addr, logic [31:0] val);
      data_we = 1'b1; data_addr = 12'(addr); data_write_value = val;
      pix(0, 0, 0);
      data_we = 1'b0;
   endtask

   task automatic frames_pulse(int n);
      flush();
      for (int i = 0; i < n; i++) begin
         frame_start = 1'b1;
         pix(0, 0, 0);
         frame_start = 1'b0;
         frames++;
      end
   endtask

   task automatic scan(int x0, int x1, int y0, int y1);
      for (int y = y0; y <= y1; y++)
         for (int x = x0; x <= x1; x++)
            pix(1, x, y);
      flush();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      dvec_t dtab [10];
      dtab[0] = '{1, 12'd0,    32'h00F00F41, 0, 32'h0};
      dtab[1] = '{0, 12'd0,    32'h0,        1, 32'h00F00F41};
      dtab[2] = '{1, 12'd0,    32'h12345678, 1, 32'h00F00F41};
      dtab[3] = '{0, 12'd0,    32'h0,        1, 32'h12345678};
      dtab[4] = '{1, 12'd2400, 32'hDEADBEEF, 1, 32'h0};
      dtab[5] = '{0, 12'd2400, 32'h0,        1, 32'h0};
      dtab[6] = '{0, 12'd0,    32'h0,        1, 32'h12345678};
      dtab[7] = '{1, 12'd2399, 32'hCAFEF00D, 0, 32'h0};
      dtab[8] = '{0, 12'd2399, 32'h0,        1, 32'hCAFEF00D};
      dtab[9] = '{0, 12'd4095, 32'h0,        1, 32'h0};

      @(negedge clk); @(negedge clk);
      check("rst_pixel_out", 32'(pixel_out), 32'h0);
      check("rst_valid_out", 32'(pixel_valid_out), 32'h0);
      check("rst_read", data_read_value, 32'h0);
      rst = 1'b0;

      // Data port table
      foreach (dtab[i]) begin
         data_we = dtab[i].we; data_addr = dtab[i].addr; data_write_value = dtab[i].wdata;
         pix(0, 0, 0);
         if (dtab[i].chk) check($sformatf("data_rd[%0d]", i), data_read_value, dtab[i].exp_rd);
      end
      data_we = 1'b0;

      // Glyph scan of 'A' on line 5
      wr(0, 32'h00F0F041);
      scan(0, 7, 5, 5);

      // VGA read of a cell written in the same cycle sees the old word
      data_we = 1'b1; data_addr = 12'd0; data_write_value = 32'h0AB0CD41;
      pix(1, 1, 5);
      data_we = 1'b0;
      pix(1, 1, 5); pix(1, 0, 5);
      flush();

      // Blink: one short of the half period, then the full period
      wr(0, 32'h00F0F0C1);
      frames_pulse(29);
      pix(1, 1, 5); flush();
      frames_pulse(1);
      scan(0, 7, 0, 15);
      frames_pulse(30);
      scan(0, 7, 5, 5);

      // Cursor at column 3, row 2
      wr(163, 32'h123ABC42);
      cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 5'd2;
      scan(24, 31, 45, 47);
      frames_pulse(30);
      scan(24, 31, 46, 47);
      frames_pulse(30);
      cursor_en = 1'b0;

      // Out-of-area blanking
      pix(1, 640, 0); pix(1, 0, 480); pix(1, 639, 479); pix(1, 640, 480);
      flush();

      // Randomized scan over rows 0..3 with concurrent writes and cursor moves
      for (int i = 0; i < 320; i++) wr(i, $urandom());
      for (int i = 0; i < 400; i++) begin
         int x, y;
         if ($urandom_range(0, 15) == 0) begin
            cursor_en  = 1'($urandom_range(0, 1));
            cursor_col = 7'($urandom_range(0, 90));
            cursor_row = 5'($urandom_range(0, 4));
         end
         x = $urandom_range(0, 639);
         y = $urandom_range(0, 63);
         case ($urandom_range(0, 9))
            0: x = $urandom_range(640, 1023);
            1: y = $urandom_range(480, 1023);
            default: ;
         endcase
         data_we          = ($urandom_range(0, 5) == 0);
         data_addr        = 12'($urandom_range(0, 319));
         data_write_value = $urandom();
         pix($urandom_range(0, 3) != 0, x, y);
      end
      data_we = 1'b0;
      cursor_en = 1'b0;
      flush();

      // Reset in the middle of a valid stream
      pix(1, 8, 5); pix(1, 9, 5); pix(1, 10, 5);
      #2 rst = 1'b1;
      #1;
      check("midrst_pixel_out", 32'(pixel_out), 32'h0);
      check("midrst_valid_out", 32'(pixel_valid_out), 32'h0);
      pixel_valid_in = 1'b0;
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      q.delete();
      frames = 0;
      check("postrst_read", data_read_value, 32'h0);
      check("postrst_valid", 32'(pixel_valid_out), 32'h0);
      pix(1, 9, 5);
      check("rst_lat_1", 32'(pixel_valid_out), 32'h0);
      pix(0, 0, 0);
      check("rst_lat_2", 32'(pixel_valid_out), 32'h0);
      pix(0, 0, 0);
      pix(0, 0, 0);
      flush();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
